// File: rtl/servo_pwm_capture.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : servo_pwm_capture
// Description : Servo PWM receiver. Measures the high-pulse width and the
//               rising-to-rising frame period in 1 us units, and flags
//               out-of-range widths and missing rising edges (timeout).
// Revision    : 1.0 - initial release
// ============================================================================
module servo_pwm_capture #(
    parameter int CLK_PER_US = 125,
    parameter int MIN_WIDTH  = 500,
    parameter int MAX_WIDTH  = 2500,
    parameter int TIMEOUT_US = 25000,
    parameter int W          = 15
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         pwm_in,
    output logic [W-1:0] width,
    output logic         width_valid,
    output logic [W-1:0] period,
    output logic         in_range,
    output logic         timeout,
    output logic [1:0]   state_dbg
);

    localparam int            c_PW       = (CLK_PER_US > 1) ? $clog2(CLK_PER_US) : 1;
    localparam logic [c_PW-1:0] c_PRE_LAST = c_PW'(CLK_PER_US - 1);
    localparam logic [W-1:0]  c_CNT_MAX  = {W{1'b1}};
    localparam logic [W-1:0]  c_MIN      = W'(MIN_WIDTH);
    localparam logic [W-1:0]  c_MAX      = W'(MAX_WIDTH);
    localparam logic [W-1:0]  c_TIMEOUT  = W'(TIMEOUT_US);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HIGH = 2'd1,
        S_LOW  = 2'd2
    } state_t;

    state_t            r_state;
    logic              r_s1;
    logic              r_s2;
    logic              r_s3;
    logic [c_PW-1:0]   r_pre;
    logic [W-1:0]      r_hi_cnt;
    logic [W-1:0]      r_per_cnt;
    logic              r_wv_pend;

    logic              w_rise;
    logic              w_fall;
    logic              w_tick;
    logic [W-1:0]      w_hi_next;
    logic [W-1:0]      w_per_next;
    logic              w_tmo_hit;

    // Synchronizer is deliberately not reset: it keeps tracking the pin
    // during reset, so a level already high at release is not seen as a rise.
    always_ff @(posedge clk) begin
        r_s1 <= pwm_in;
        r_s2 <= r_s1;
        r_s3 <= r_s2;
    end

    assign w_rise = r_s2 & ~r_s3;
    assign w_fall = ~r_s2 & r_s3;
    assign w_tick = (r_pre == c_PRE_LAST);

    // Counter values including a tick on this very edge, so a pulse of
    // exactly N us reads back as N rather than N-1.
    assign w_hi_next  = (w_tick && (r_hi_cnt  != c_CNT_MAX)) ? r_hi_cnt  + W'(1) : r_hi_cnt;
    assign w_per_next = (w_tick && (r_per_cnt != c_CNT_MAX)) ? r_per_cnt + W'(1) : r_per_cnt;
    // >= so a timeout tick coinciding with a fall is caught on the next tick.
    assign w_tmo_hit  = w_tick && (w_per_next >= c_TIMEOUT);

    assign state_dbg = r_state;

    // Microsecond prescaler, re-phased to every detected rising edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pre <= '0;
        end else if (w_rise || w_tick) begin
            r_pre <= '0;
        end else begin
            r_pre <= r_pre + c_PW'(1);
        end
    end

    // Measurement FSM with its counters and registered results.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_hi_cnt    <= '0;
            r_per_cnt   <= '0;
            r_wv_pend   <= 1'b0;
            width       <= '0;
            width_valid <= 1'b0;
            period      <= '0;
            in_range    <= 1'b0;
            timeout     <= 1'b0;
        end else begin
            r_wv_pend   <= 1'b0;
            width_valid <= r_wv_pend;
            case (r_state)
                S_IDLE: begin
                    if (w_rise) begin
                        r_state   <= S_HIGH;
                        r_hi_cnt  <= '0;
                        r_per_cnt <= '0;
                        timeout   <= 1'b0;
                    end
                end
                S_HIGH: begin
                    if (w_fall) begin
                        r_state   <= S_LOW;
                        width     <= w_hi_next;
                        in_range  <= (w_hi_next >= c_MIN) && (w_hi_next <= c_MAX);
                        r_wv_pend <= 1'b1;
                        r_per_cnt <= w_per_next;
                    end else if (w_tmo_hit) begin
                        r_state  <= S_IDLE;
                        timeout  <= 1'b1;
                        in_range <= 1'b0;
                    end else begin
                        r_hi_cnt  <= w_hi_next;
                        r_per_cnt <= w_per_next;
                    end
                end
                S_LOW: begin
                    if (w_rise) begin
                        r_state   <= S_HIGH;
                        period    <= w_per_next;
                        r_hi_cnt  <= '0;
                        r_per_cnt <= '0;
                        timeout   <= 1'b0;
                    end else if (w_tmo_hit) begin
                        r_state  <= S_IDLE;
                        timeout  <= 1'b1;
                        in_range <= 1'b0;
                    end else begin
                        r_per_cnt <= w_per_next;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_servo_pwm_capture.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_servo_pwm_capture
// Description : Self-checking bench for servo_pwm_capture, scaled timing
//               (4 clk per us, 50..250 us range, 2500 us timeout).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_servo_pwm_capture;

    localparam int CPU  = 4;
    localparam int MINW = 50;
    localparam int MAXW = 250;
    localparam int TMO  = 2500;
    localparam int W    = 15;

    logic         clk = 1'b0;
    logic         rst;
    logic         pwm_in;
    logic [W-1:0] width;
    logic         width_valid;
    logic [W-1:0] period;
    logic         in_range;
    logic         timeout;
    logic [1:0]   state_dbg;

    servo_pwm_capture #(
        .CLK_PER_US (CPU),
        .MIN_WIDTH  (MINW),
        .MAX_WIDTH  (MAXW),
        .TIMEOUT_US (TMO),
        .W          (W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .pwm_in      (pwm_in),
        .width       (width),
        .width_valid (width_valid),
        .period      (period),
        .in_range    (in_range),
        .timeout     (timeout),
        .state_dbg   (state_dbg)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // Input transition bookkeeping (edge at which the measurement reacts).
    int ev_rise = -100;
    int ev_fall = -100;
    int last_rise_cyc = 0;
    int last_fall_cyc = 0;

    // Observations used by the literal checks.
    int wv_count     = 0;
    int last_wv_edge = 0;
    int tmo_edge     = 0;
    bit prev_tmo     = 1'b0;

    // Event-level model: 0 idle, 1 high, 2 low.
    int m_state     = 0;
    int m_last_rise = 0;
    int m_width     = 0;
    int m_period    = 0;
    bit m_inr       = 1'b0;
    bit m_tmo       = 1'b0;
    int m_wv_edge   = -1;

    task automatic model_reset();
        m_state   = 0;
        m_width   = 0;
        m_period  = 0;
        m_inr     = 1'b0;
        m_tmo     = 1'b0;
        m_wv_edge = -1;
    endtask

    // Advance the model one edge, then compare all outputs just after it.
    always @(posedge clk) begin
        cyc = cyc + 1;
        if (rst) begin
            model_reset();
        end else if (cyc == ev_rise) begin
            if (m_state == 2) m_period = (cyc - m_last_rise) / CPU;
            m_state     = 1;
            m_tmo       = 1'b0;
            m_last_rise = cyc;
        end else if (cyc == ev_fall) begin
            if (m_state == 1) begin
                m_width   = (cyc - m_last_rise) / CPU;
                m_inr     = (m_width >= MINW) && (m_width <= MAXW);
                m_state   = 2;
                m_wv_edge = cyc + 1;
            end
        end else if (m_state != 0 && (cyc - m_last_rise) == TMO * CPU) begin
            m_state = 0;
            m_tmo   = 1'b1;
            m_inr   = 1'b0;
        end
        #1;
        checks = checks + 1;
        if (int'(width) != m_width || width_valid != (cyc == m_wv_edge) ||
            int'(period) != m_period || in_range != m_inr ||
            timeout != m_tmo || int'(state_dbg) != m_state) begin
            failures = failures + 1;
            $display("FAIL model cyc=%0d got w=%0d wv=%0d p=%0d ir=%0d to=%0d st=%0d exp w=%0d wv=%0d p=%0d ir=%0d to=%0d st=%0d",
                     cyc, width, width_valid, period, in_range, timeout, state_dbg,
                     m_width, (cyc == m_wv_edge), m_period, m_inr, m_tmo, m_state);
        end
        if (width_valid) begin
            wv_count     = wv_count + 1;
            last_wv_edge = cyc;
        end
        if (timeout && !prev_tmo) tmo_edge = cyc;
        prev_tmo = timeout;
    end

    task automatic chk(input string name, input int act, input int exp);
        checks = checks + 1;
        if (act != exp) begin
            failures = failures + 1;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic set_in(input bit v);
        @(negedge clk);
        pwm_in = v;
        if (v) begin
            ev_rise       = cyc + 3;
            last_rise_cyc = cyc;
        end else begin
            ev_fall       = cyc + 3;
            last_fall_cyc = cyc;
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    // High for exactly hi clocks, then low for exactly lo clocks.
    task automatic pulse(input int hi, input int lo);
        set_in(1'b1);
        wait_clk(hi - 1);
        set_in(1'b0);
        wait_clk(lo - 1);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, " width"},  int'(width),       0);
        chk({tag, " wv"},     int'(width_valid), 0);
        chk({tag, " period"}, int'(period),      0);
        chk({tag, " inr"},    int'(in_range),    0);
        chk({tag, " tmo"},    int'(timeout),     0);
        chk({tag, " state"},  int'(state_dbg),   0);
    endtask

    int rng_w   [4] = '{49, 50, 250, 251};
    int rng_exp [4] = '{0, 1, 1, 0};
    int saved_period;

    initial begin
        rst    = 1'b1;
        pwm_in = 1'b0;
        wait_clk(5);
        chk_reset_vals("reset");
        rst = 1'b0;
        wait_clk(10);

        // Reset asserted mid-pulse; the fall after release is ignored.
        set_in(1'b1);
        wait_clk(100);
        rst = 1'b1;
        wait_clk(5);
        chk_reset_vals("midpulse_reset");
        rst = 1'b0;
        wv_count = 0;
        wait_clk(50);
        set_in(1'b0);
        wait_clk(50);
        chk("ignored_fall wv_count", wv_count, 0);
        chk("ignored_fall state", int'(state_dbg), 0);
        pulse(600, 400);
        chk("first_pair wv_count", wv_count, 1);
        chk("first_pair width", int'(width), 150);

        // Three 2000 us frames with 150 us pulses.
        wv_count = 0;
        for (int i = 0; i < 3; i++) pulse(600, 7400);
        chk("frames wv_count", wv_count, 3);
        chk("frames width", int'(width), 150);
        chk("frames period", int'(period), 2000);
        chk("frames inr", int'(in_range), 1);
        chk("frames wv_latency", last_wv_edge - last_fall_cyc, 4);

        // Range boundaries.
        for (int i = 0; i < 4; i++) begin
            pulse(rng_w[i] * CPU, 400);
            chk("range width", int'(width), rng_w[i]);
            chk("range inr", int'(in_range), rng_exp[i]);
        end

        // Stuck low after a pulse.
        pulse(600, 12000);
        chk("stuck_low tmo", int'(timeout), 1);
        chk("stuck_low inr", int'(in_range), 0);
        chk("stuck_low width", int'(width), 150);
        chk("stuck_low state", int'(state_dbg), 0);
        chk("stuck_low tmo_time", tmo_edge - last_rise_cyc, 3 + TMO * CPU);
        saved_period = int'(period);
        set_in(1'b1);
        wait_clk(10);
        chk("recover tmo", int'(timeout), 0);
        chk("recover period_held", int'(period), saved_period);
        chk("recover state", int'(state_dbg), 1);
        set_in(1'b0);
        wait_clk(400);

        // Stuck high, then a normal 100 us pulse.
        wv_count = 0;
        set_in(1'b1);
        wait_clk(12000);
        chk("stuck_high tmo", int'(timeout), 1);
        chk("stuck_high wv_count", wv_count, 0);
        chk("stuck_high state", int'(state_dbg), 0);
        set_in(1'b0);
        wait_clk(99);
        pulse(400, 400);
        chk("after_high width", int'(width), 100);
        chk("after_high tmo", int'(timeout), 0);
        chk("after_high inr", int'(in_range), 1);
        chk("after_high wv_count", wv_count, 1);

        // Glitches and sub-microsecond pulses.
        wv_count = 0;
        pulse(2, 100);
        chk("glitch width", int'(width), 0);
        chk("glitch inr", int'(in_range), 0);
        pulse(3, 100);
        chk("short width", int'(width), 0);
        chk("short inr", int'(in_range), 0);
        chk("short wv_count", wv_count, 2);
        pulse(20, 100);
        chk("clk20 width", int'(width), 5);
        chk("clk20 inr", int'(in_range), 0);
        chk("clk20 wv_count", wv_count, 3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
